// File: rtl/bus_xfer_arbiter.sv
// bus_xfer_arbiter: owns the shared internal bus, one-hot drive enables with an all-off turnaround
// cycle between owners, and captures the bus at the end of each grant. Macro ARB_FIXED_PRIO_EN selects fixed priority.
module bus_xfer_arbiter #(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 1,
   parameter int IDW         = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant_en,
   output logic [IDW-1:0]   grant_id,
   output logic             busy_drive,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] capture_data,
   output logic             capture_valid
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("bus_xfer_arbiter: HOLD_CYCLES must be in 1..15");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("bus_xfer_arbiter: N_REQ must be in 2..8");
   end
   if (IDW != $clog2(N_REQ)) begin : g_bad_idw
      $error("bus_xfer_arbiter: IDW must equal clog2(N_REQ)");
   end

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] grant_en_q, grant_en_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic             busy_q, busy_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0] capture_data_q, capture_data_d;
   logic             capture_valid_q, capture_valid_d;
   logic [IDW-1:0]   search_start;
   logic [IDW-1:0]   winner;
   logic             win_found;

`ifdef ARB_FIXED_PRIO_EN
   assign search_start = '0;
`else
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   assign search_start = rr_ptr_q;
`endif

   // First requester at or above search_start, wrapping past the top index.
   always_comb begin
      int idx;
      idx       = 0;
      winner    = '0;
      win_found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(search_start) + i) % N_REQ;
         if (!win_found && req[idx[IDW-1:0]]) begin
            win_found = 1'b1;
            winner    = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      grant_en_d      = grant_en_q;
      grant_id_d      = grant_id_q;
      busy_d          = busy_q;
      hold_cnt_d      = hold_cnt_q;
      capture_data_d  = capture_data_q;
      capture_valid_d = capture_valid_q;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_d        = rr_ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_en_d = N_REQ'(1) << winner;
               grant_id_d = winner;
               busy_d     = 1'b1;
               hold_cnt_d = 4'(HOLD_CYCLES - 1);
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (hold_cnt_q != 4'd0) begin
               hold_cnt_d = hold_cnt_q - 4'd1;
            end else begin
               capture_data_d  = bus_in;
               capture_valid_d = 1'b1;
               grant_en_d      = '0;
               busy_d          = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
               rr_ptr_d        = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
`endif
               state_d         = ST_TURN;
            end
         end
         ST_TURN: begin
            capture_valid_d = 1'b0;
            state_d         = ST_IDLE;
         end
         default: begin
            grant_en_d      = '0;
            busy_d          = 1'b0;
            capture_valid_d = 1'b0;
            state_d         = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         grant_en_q      <= '0;
         grant_id_q      <= '0;
         busy_q          <= 1'b0;
         hold_cnt_q      <= 4'd0;
         capture_data_q  <= '0;
         capture_valid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr_q        <= '0;
`endif
      end else begin
         state_q         <= state_d;
         grant_en_q      <= grant_en_d;
         grant_id_q      <= grant_id_d;
         busy_q          <= busy_d;
         hold_cnt_q      <= hold_cnt_d;
         capture_data_q  <= capture_data_d;
         capture_valid_q <= capture_valid_d;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr_q        <= rr_ptr_d;
`endif
      end
   end

   assign grant_en      = grant_en_q;
   assign grant_id      = grant_id_q;
   assign busy_drive    = busy_q;
   assign capture_data  = capture_data_q;
   assign capture_valid = capture_valid_q;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Self-checking bench for bus_xfer_arbiter: two instances (HOLD_CYCLES=1 and 3) share stimulus;
// directed scenarios plus randomized traffic against a transfer-level reference model.
module tb_bus_xfer_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] bus_in;
   logic [3:0]  o_ge   [2];
   logic [1:0]  o_id   [2];
   logic        o_busy [2];
   logic [15:0] o_cd   [2];
   logic        o_cv   [2];
   int          total = 0;
   int          bad   = 0;

`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   bus_xfer_arbiter #(.N_REQ(4), .WIDTH(16), .HOLD_CYCLES(1), .IDW(2)) dut1 (
      .clk(clk), .rst(rst), .req(req), .grant_en(o_ge[0]), .grant_id(o_id[0]),
      .busy_drive(o_busy[0]), .bus_in(bus_in), .capture_data(o_cd[0]), .capture_valid(o_cv[0])
   );

   bus_xfer_arbiter #(.N_REQ(4), .WIDTH(16), .HOLD_CYCLES(3), .IDW(2)) dut3 (
      .clk(clk), .rst(rst), .req(req), .grant_en(o_ge[1]), .grant_id(o_id[1]),
      .busy_drive(o_busy[1]), .bus_in(bus_in), .capture_data(o_cd[1]), .capture_valid(o_cv[1])
   );

   always #5 clk = ~clk;

   // Reference model: an owner with an age, a turnaround flag, and the next search start.
   int          m_owner [2];
   int          m_age   [2];
   int          m_ptr   [2];
   logic        m_turn  [2];
   logic [1:0]  m_id    [2];
   logic [15:0] m_cd    [2];
   logic        m_cv    [2];

   function automatic int hold_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int pick(input logic [3:0] r, input int start);
      int idx;
      for (int i = 0; i < 4; i++) begin
         idx = (start + i) % 4;
         if (r[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1;
         m_age[k]   = 0;
         m_ptr[k]   = 0;
         m_turn[k]  = 1'b0;
         m_id[k]    = 2'd0;
         m_cd[k]    = 16'h0;
         m_cv[k]    = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input logic [3:0] r, input logic [15:0] b);
      if (m_owner[k] >= 0) begin
         if (m_age[k] < hold_of(k) - 1) begin
            m_age[k] = m_age[k] + 1;
         end else begin
            m_cd[k]    = b;
            m_cv[k]    = 1'b1;
            m_ptr[k]   = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
            m_turn[k]  = 1'b1;
         end
      end else if (m_turn[k]) begin
         m_turn[k] = 1'b0;
         m_cv[k]   = 1'b0;
      end else if (r != 4'h0) begin
         m_owner[k] = pick(r, FIXED ? 0 : m_ptr[k]);
         m_id[k]    = m_owner[k][1:0];
         m_age[k]   = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'h0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      req    = 4'hF;
      bus_in = 16'hFFFF;
      repeat (3) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            total++;
            if ({o_ge[k], o_busy[k], o_cv[k], o_cd[k]} !== 22'h0) begin
               bad++;
               $display("[TB] FAIL reset_outputs[%0d]: got ge=%b busy=%b cv=%b cd=%h want all zero",
                        k, o_ge[k], o_busy[k], o_cv[k], o_cd[k]);
            end
         end
      end
      req = 4'h0;
      rst = 1'b0;
   endtask

   task automatic test_single_source();
      do_reset();
      req    = 4'b0100;
      bus_in = 16'hA5A5;
      @(posedge clk); #1;
      total++;
      if ({o_ge[0], o_id[0], o_busy[0]} !== {4'b0100, 2'd2, 1'b1}) begin
         bad++;
         $display("[TB] FAIL single_grant: got ge=%b id=%0d busy=%b want ge=0100 id=2 busy=1",
                  o_ge[0], o_id[0], o_busy[0]);
      end
      req = 4'h0;
      @(posedge clk); #1;
      total++;
      if ({o_ge[0], o_busy[0], o_cv[0], o_cd[0]} !== {4'b0000, 1'b0, 1'b1, 16'hA5A5}) begin
         bad++;
         $display("[TB] FAIL single_capture: got ge=%b busy=%b cv=%b cd=%h want ge=0000 busy=0 cv=1 cd=a5a5",
                  o_ge[0], o_busy[0], o_cv[0], o_cd[0]);
      end
      @(posedge clk); #1;
      total++;
      if ({o_cv[0], o_cd[0]} !== {1'b0, 16'hA5A5}) begin
         bad++;
         $display("[TB] FAIL single_pulse_end: got cv=%b cd=%h want cv=0 cd=a5a5", o_cv[0], o_cd[0]);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ge;
      do_reset();
      req = 4'hF;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         exp_ge = 4'h0;
         if (k % 3 == 1) exp_ge = FIXED ? 4'b0001 : 4'(1 << (((k - 1) / 3) % 4));
         total++;
         if (o_ge[0] !== exp_ge || o_cv[0] !== (k % 3 == 2)) begin
            bad++;
            $display("[TB] FAIL rr_cycle%0d: got ge=%b cv=%b want ge=%b cv=%b",
                     k, o_ge[0], o_cv[0], exp_ge, (k % 3 == 2));
         end
      end
      req = 4'h0;
   endtask

   task automatic test_hold3();
      logic [15:0] words [3];
      words = '{16'h1111, 16'h2222, 16'h3333};
      do_reset();
      req    = 4'b0001;
      bus_in = 16'h0000;
      @(posedge clk); #1;
      req = 4'h0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({o_ge[1], o_cv[1]} !== {4'b0001, 1'b0}) begin
            bad++;
            $display("[TB] FAIL hold3_cycle%0d: got ge=%b cv=%b want ge=0001 cv=0", i, o_ge[1], o_cv[1]);
         end
         bus_in = words[i];
         @(posedge clk); #1;
      end
      total++;
      if ({o_ge[1], o_cv[1], o_cd[1]} !== {4'b0000, 1'b1, 16'h3333}) begin
         bad++;
         $display("[TB] FAIL hold3_capture: got ge=%b cv=%b cd=%h want ge=0000 cv=1 cd=3333",
                  o_ge[1], o_cv[1], o_cd[1]);
      end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      req    = 4'b0100;
      bus_in = 16'hBEEF;
      @(posedge clk); #1;
      req = 4'b1000;
      n   = 0;
      while (o_ge[1] !== 4'b1000 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (o_ge[1] !== 4'b1000) begin
         bad++;
         $display("[TB] FAIL async_setup_timeout: got ge=%b want 1000 within 12 cycles", o_ge[1]);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      total++;
      if ({o_ge[1], o_busy[1], o_cv[1]} !== {4'b0000, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL async_drop: got ge=%b busy=%b cv=%b want all zero before next edge",
                  o_ge[1], o_busy[1], o_cv[1]);
      end
      @(posedge clk); #1;
      total++;
      if ({o_cv[1], o_cd[1]} !== {1'b0, 16'h0000}) begin
         bad++;
         $display("[TB] FAIL async_no_capture: got cv=%b cd=%h want cv=0 cd=0000", o_cv[1], o_cd[1]);
      end
      req = 4'b1010;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (o_ge[k] !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL async_first_grant[%0d]: got ge=%b want 0010", k, o_ge[k]);
         end
      end
      req = 4'h0;
   endtask

   task automatic test_two_sources();
      logic [3:0] exp_ge;
      do_reset();
      req = 4'b1010;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         exp_ge = 4'h0;
         if (k % 3 == 1) exp_ge = (FIXED || ((k - 1) / 3) % 2 == 0) ? 4'b0010 : 4'b1000;
         total++;
         if (o_ge[0] !== exp_ge) begin
            bad++;
            $display("[TB] FAIL two_src_cycle%0d: got ge=%b want %b", k, o_ge[0], exp_ge);
         end
      end
      req = 4'h0;
   endtask

   task automatic test_random();
      logic [3:0] exp_ge;
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
         req    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         bus_in = 16'($urandom);
         for (int k = 0; k < 2; k++) model_step(k, req, bus_in);
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            exp_ge = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'h0;
            total++;
            if ({o_ge[k], o_busy[k]} !== {exp_ge, exp_ge != 4'h0}) begin
               bad++;
               $display("[TB] FAIL rand_grant[%0d] c=%0d: got ge=%b busy=%b want ge=%b busy=%b",
                        k, c, o_ge[k], o_busy[k], exp_ge, exp_ge != 4'h0);
            end
            total++;
            if (o_id[k] !== m_id[k]) begin
               bad++;
               $display("[TB] FAIL rand_id[%0d] c=%0d: got %0d want %0d", k, c, o_id[k], m_id[k]);
            end
            total++;
            if ({o_cv[k], o_cd[k]} !== {m_cv[k], m_cd[k]}) begin
               bad++;
               $display("[TB] FAIL rand_capture[%0d] c=%0d: got cv=%b cd=%h want cv=%b cd=%h",
                        k, c, o_cv[k], o_cd[k], m_cv[k], m_cd[k]);
            end
         end
      end
      req = 4'h0;
   endtask

   initial begin
      rst    = 1'b1;
      req    = 4'h0;
      bus_in = 16'h0;
      #2;
      test_reset();
      test_single_source();
      test_round_robin();
      test_hold3();
      test_async_reset();
      test_two_sources();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
